// File: rtl/vend_requester.sv
`default_nettype none
// ============================================================================
// Module   : vend_requester
// Purpose  : Requester FSM for a tea/coffee vending machine. It accepts a
//            customer request, checks stock, selects the product, pays with
//            a one- or two-unit coin, then waits a bounded time for the
//            delivery and reports the outcome with a one-cycle done pulse.
//            Successful deliveries are counted per product (saturating).
// Ports    : clk, rst               - clock, async active-high reset
//            req_valid/req_ready    - request handshake (ready only in IDLE)
//            req_item, req_coin2    - product (1=tea) and coin type (1=two-unit)
//            tea/coffee_available   - stock reported by the machine
//            deliver_tea/coffee     - delivery responses from the machine
//            change                 - change response from the machine
//            item, coin1, coin2     - drives to the machine
//            done_valid/status/change - transaction result
//            tea_count/coffee_count - saturating success counters
// Revision : 1.0 - initial release
// ============================================================================
module vend_requester #(
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_item,
  input  logic             req_coin2,
  output logic             req_ready,
  input  logic [1:0]       tea_available,
  input  logic [1:0]       coffee_available,
  input  logic             deliver_tea,
  input  logic             deliver_coffee,
  input  logic             change,
  output logic             item,
  output logic             coin1,
  output logic             coin2,
  output logic             done_valid,
  output logic [1:0]       done_status,
  output logic             done_change,
  output logic [CNT_W-1:0] tea_count,
  output logic [CNT_W-1:0] coffee_count
);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_SOLD_OUT = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_PROTOCOL = 2'b11;

  localparam logic [3:0]       TMO_LOAD = 4'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SELECT = 3'd2,
    S_PAY    = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       lat_item;
  logic       lat_coin2;
  logic [3:0] wait_cnt;

  // Result of the transaction, computed on the cycle that leaves for DONE
  logic       fin;
  logic [1:0] fin_status;
  logic       fin_change;

  logic       stock_ok;
  logic       exp_del;
  logic       oth_del;

  assign stock_ok = lat_item ? (tea_available != 2'd0) : (coffee_available != 2'd0);
  assign exp_del  = lat_item ? deliver_tea    : deliver_coffee;
  assign oth_del  = lat_item ? deliver_coffee : deliver_tea;

  // --------------------------------------------------------------------------
  // Next-state and result logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    fin        = 1'b0;
    fin_status = ST_OK;
    fin_change = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (stock_ok) begin
          state_nxt = S_SELECT;
        end else begin
          state_nxt  = S_DONE;
          fin        = 1'b1;
          fin_status = ST_SOLD_OUT;
        end
      end
      S_SELECT: state_nxt = S_PAY;
      S_PAY:    state_nxt = S_WAIT;
      S_WAIT: begin
        // Any delivery is evaluated before the timeout so that a delivery on
        // the last counted cycle still wins.
        if (oth_del) begin
          state_nxt  = S_DONE;
          fin        = 1'b1;
          fin_status = ST_PROTOCOL;
          fin_change = change;
        end else if (exp_del) begin
          state_nxt  = S_DONE;
          fin        = 1'b1;
          fin_status = (change == lat_coin2) ? ST_OK : ST_PROTOCOL;
          fin_change = change;
        end else if (wait_cnt <= 4'd1) begin
          state_nxt  = S_DONE;
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Coins and handshake are decoded from state so an asynchronous reset
  // removes them in the same cycle.
  assign req_ready  = (state == S_IDLE);
  assign coin1      = (state == S_PAY) && !lat_coin2;
  assign coin2      = (state == S_PAY) &&  lat_coin2;
  assign done_valid = (state == S_DONE);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lat_item     <= 1'b0;
      lat_coin2    <= 1'b0;
      wait_cnt     <= 4'd0;
      item         <= 1'b0;
      done_status  <= ST_OK;
      done_change  <= 1'b0;
      tea_count    <= '0;
      coffee_count <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && req_valid) begin
        lat_item  <= req_item;
        lat_coin2 <= req_coin2;
      end

      if (state == S_PAY) begin
        wait_cnt <= TMO_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // item is driven from SELECT onward and otherwise holds its last value
      if (state == S_CHECK && stock_ok) begin
        item <= lat_item;
      end

      if (fin) begin
        done_status <= fin_status;
        done_change <= fin_change;
        if (fin_status == ST_OK) begin
          if (lat_item) begin
            if (tea_count != CNT_MAX) tea_count <= tea_count + CNT_ONE;
          end else begin
            if (coffee_count != CNT_MAX) coffee_count <= coffee_count + CNT_ONE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_requester
// Purpose  : Self-checking bench for vend_requester. Each transaction is
//            described by its parameters (product, coin, stock, delivery
//            cycle and kind, change); the expected outcome, latency and
//            counters are derived from the transaction rules directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_requester;

  localparam int TMO = 4;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_item = 1'b0;
  logic          req_coin2 = 1'b0;
  logic          req_ready;
  logic [1:0]    tea_available = 2'd0;
  logic [1:0]    coffee_available = 2'd0;
  logic          deliver_tea = 1'b0;
  logic          deliver_coffee = 1'b0;
  logic          change = 1'b0;
  logic          item, coin1, coin2, done_valid, done_change;
  logic [1:0]    done_status;
  logic [CW-1:0] tea_count, coffee_count;

  vend_requester #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_item         (req_item),
    .req_coin2        (req_coin2),
    .req_ready        (req_ready),
    .tea_available    (tea_available),
    .coffee_available (coffee_available),
    .deliver_tea      (deliver_tea),
    .deliver_coffee   (deliver_coffee),
    .change           (change),
    .item             (item),
    .coin1            (coin1),
    .coin2            (coin2),
    .done_valid       (done_valid),
    .done_status      (done_status),
    .done_change      (done_change),
    .tea_count        (tea_count),
    .coffee_count     (coffee_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state, updated once per completed transaction
  int   m_tea = 0;
  int   m_cof = 0;
  int   m_status = 0;
  logic m_chg = 1'b0;
  logic m_last_item = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks of the quiescent IDLE cycle (current time is just after an edge)
  task automatic idle_checks();
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_dv",    32'(done_valid), 32'd0);
    check("idle_coins", 32'({coin2, coin1}), 32'd0);
    check("hold_status", 32'(done_status), 32'(m_status));
    check("hold_change", 32'(done_change), 32'(m_chg));
    check("hold_item",   32'(item), 32'(m_last_item));
    check("tea_count",   32'(tea_count), 32'(m_tea));
    check("coffee_count", 32'(coffee_count), 32'(m_cof));
  endtask

  // kind: 0/1 = correct product, 2 = other product, 3 = both products.
  // dly:  WAIT cycle (1..TMO) carrying the delivery; anything else = none.
  task automatic run_txn(input logic it, input logic c2, input logic [1:0] st_tea,
                         input logic [1:0] st_cof, input int dly, input int kind,
                         input logic chg);
    logic [1:0] stock;
    logic       go, delivered, e, o;
    int         exp_status, done_at;
    logic       exp_chg;

    stock     = it ? st_tea : st_cof;
    go        = (stock != 2'd0);
    delivered = go && (dly >= 1) && (dly <= TMO);
    if (!go) begin
      exp_status = 1; exp_chg = 1'b0; done_at = 2;
    end else if (delivered) begin
      if (kind <= 1) exp_status = (chg == c2) ? 0 : 3;
      else           exp_status = 3;
      exp_chg = chg; done_at = 4 + dly;
    end else begin
      exp_status = 2; exp_chg = 1'b0; done_at = 4 + TMO;
    end
    e = (kind <= 1) || (kind == 3);
    o = (kind >= 2);

    // cycle 0: IDLE, present the request
    @(posedge clk); #1;
    idle_checks();
    req_valid = 1'b1; req_item = it; req_coin2 = c2;
    tea_available = st_tea; coffee_available = st_cof;

    for (int c = 1; c <= done_at; c++) begin
      @(posedge clk); #1;
      check("ctl", 32'({req_ready, coin2, coin1, done_valid}),
            32'({1'b0, (c == 3) && go && c2, (c == 3) && go && !c2, c == done_at}));
      check("item", 32'(item), 32'((go && c >= 2) ? it : m_last_item));
      if (c == done_at) begin
        check("status", 32'(done_status), 32'(exp_status));
        check("dchange", 32'(done_change), 32'(exp_chg));
      end
      // request inputs are noise outside IDLE
      req_valid = 1'($urandom); req_item = 1'($urandom); req_coin2 = 1'($urandom);
      change = 1'($urandom);
      if (delivered && c == 3 + dly) begin
        deliver_tea    = it ? e : o;
        deliver_coffee = it ? o : e;
        change         = chg;
      end else begin
        deliver_tea = 1'b0; deliver_coffee = 1'b0;
      end
    end
    deliver_tea = 1'b0; deliver_coffee = 1'b0;

    m_status = exp_status;
    m_chg    = exp_chg;
    if (go) m_last_item = it;
    if (exp_status == 0) begin
      if (it) m_tea = (m_tea < CMAX) ? m_tea + 1 : CMAX;
      else    m_cof = (m_cof < CMAX) ? m_cof + 1 : CMAX;
    end
  endtask

  // Reset asserted mid-PAY: coins must drop at once and no done pulse follows
  task automatic reset_in_pay();
    @(posedge clk); #1;
    req_valid = 1'b1; req_item = 1'b1; req_coin2 = 1'b0;
    tea_available = 2'd3; coffee_available = 2'd3;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    check("pay_coin1", 32'(coin1), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_coins", 32'({coin2, coin1}), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_out", 32'({item, done_valid, done_status, done_change}), 32'd0);
    check("rst_cnt", 32'({tea_count, coffee_count}), 32'd0);
    m_tea = 0; m_cof = 0; m_status = 0; m_chg = 1'b0; m_last_item = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_dv", 32'({done_valid, coin2, coin1}), 32'd0);
    end
  endtask

  initial begin
    #3;
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_out", 32'({item, coin1, coin2, done_valid, done_status, done_change}), 32'd0);
    check("reset_cnt", 32'({tea_count, coffee_count}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_txn(1'b1, 1'b0, 2'd2, 2'd0, 2, 0, 1'b0);  // tea, coin1, ok
    run_txn(1'b0, 1'b1, 2'd0, 2'd1, 1, 0, 1'b1);  // coffee, coin2, ok with change
    run_txn(1'b1, 1'b0, 2'd0, 2'd3, 1, 0, 1'b0);  // tea sold out
    run_txn(1'b1, 1'b1, 2'd1, 2'd0, 0, 0, 1'b0);  // no delivery -> timeout
    run_txn(1'b1, 1'b0, 2'd1, 2'd0, TMO, 0, 1'b0); // delivery on last WAIT cycle
    run_txn(1'b1, 1'b0, 2'd1, 2'd1, 1, 2, 1'b0);  // wrong product
    run_txn(1'b1, 1'b0, 2'd1, 2'd1, 3, 3, 1'b0);  // both products
    run_txn(1'b0, 1'b0, 2'd1, 2'd1, 2, 0, 1'b1);  // change mismatch
    run_txn(1'b0, 1'b1, 2'd1, 2'd1, 1, 0, 1'b0);  // change missing

    // Randomized transactions
    for (int n = 0; n < 200; n++) begin
      run_txn(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
              int'($urandom_range(0, TMO + 1)), int'($urandom_range(0, 3)),
              1'($urandom));
    end

    reset_in_pay();

    // Saturation: 256 tea successes from zero
    for (int n = 0; n < CMAX + 1; n++) begin
      run_txn(1'b1, 1'b0, 2'd2, 2'd0, 1, 0, 1'b0);
    end
    @(posedge clk); #1;
    idle_checks();
    check("tea_sat", 32'(tea_count), 32'(CMAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
